pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge
 reset  in  1  synchronous, active-high reset
 id_RnAddr  in  5  Rn field of instruction in IF/ID
 id_RmAddr  in  5  Rm field of instruction in IF/ID
 id_usesRn  in  1  ID instruction reads Rn
 id_usesRm  in  1  ID instruction reads Rm (R-type, STUR data)
 id_isCondBr  in  1  ID instruction is B.cond (reads flags)
 ex_RdAddr  in  5  RdAddr output of ID/EX pipeline register
 ex_read_enable  in  1  read_enable output of ID/EX (load in EX)
 ex_RegWrite  in  1  RegWrite output of ID/EX
 ex_flagEn  in  1  flagEn output of ID/EX
 ex_brTaken  in  1  branch in EX resolved taken
 pc_hold  out  1  PC keeps current value
 ifid_hold  out  1  IF/ID register keeps current value
 ifid_flush  out  1  IF/ID loads NOP (all zero)
 idex_bubble  out  1  ID/EX control fields (RegWrite, MemWrite, read_enable, flagEn, UncondBr) loaded as 0
 ctrl_state  out  2  FSM state: 0 RUN, 1 FLUSH
 stall_count  out  16  bubble cycles caused by load-use/flag hazards
 flush_count  out  8  taken-branch flush events

Function
REQ-002 SHALL define load_use = ex_read_enable & ex_RegWrite & (ex_RdAddr != 31) & ((id_usesRn & id_RnAddr == ex_RdAddr) | (id_usesRm & id_RmAddr == ex_RdAddr)).
REQ-003 SHALL define flag_haz = ex_flagEn & id_isCondBr.
REQ-004 SHALL treat register 31 (XZR) as never producing a hazard.
REQ-005 In RUN with ex_brTaken=1: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0; next state FLUSH; flush_count increments.
REQ-006 In RUN with ex_brTaken=0 and (load_use | flag_haz): pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0; state stays RUN; stall_count increments.
REQ-007 In RUN with no condition: all four control outputs 0.
REQ-008 Priority SHALL be ex_brTaken > load_use > flag_haz; a taken branch suppresses stall outputs and stall_count increment in that cycle.
REQ-009 FLUSH SHALL last exactly one cycle: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0; next state RUN unconditionally; hazard inputs ignored, no counter change.
REQ-010 ex_brTaken asserted while in FLUSH SHALL be ignored (content of ID/EX is already a bubble).
REQ-011 Control outputs SHALL be combinational from ctrl_state and current inputs (same-cycle effect); ctrl_state and counters registered.
REQ-012 A single load-use SHALL produce exactly one bubble cycle; on the next cycle ID/EX holds the bubble so hazard clears without FSM memory.
REQ-013 stall_count SHALL saturate at 16'hFFFF; flush_count SHALL saturate at 8'hFF; no wrap-around.
REQ-014 pc_hold and ifid_hold SHALL always be equal; ifid_flush and ifid_hold SHALL never both be 1.

Reset
REQ-015 While reset=1 at a rising edge: ctrl_state=RUN, stall_count=0, flush_count=0.
REQ-016 While reset=1, pc_hold, ifid_hold, ifid_flush, idex_bubble SHALL all be 0 regardless of inputs.
REQ-017 Reset asserted during FLUSH SHALL return to RUN on that edge with no pending flush cycle.

Verification
REQ-018 Load X3 in EX (ex_RdAddr=3, read_enable=1, RegWrite=1), ID id_RnAddr=3 usesRn=1 -> one cycle pc_hold=ifid_hold=idex_bubble=1, stall_count 0->1; next cycle (ex_read_enable=0) all 0.
REQ-019 Same as REQ-018 but ex_RdAddr=id_RmAddr=31 -> no stall, stall_count unchanged.
REQ-020 ex_brTaken=1 simultaneous with load_use -> cycle1 ifid_flush=idex_bubble=1, pc_hold=0, state->FLUSH, flush_count=1, stall_count=0; cycle2 flush again, state->RUN.
REQ-021 ex_flagEn=1 with id_isCondBr=1 -> one bubble cycle; ex_flagEn=1 with id_isCondBr=0 -> no stall.
REQ-022 Preload via 65540 consecutive hazard cycles -> stall_count holds 16'hFFFF; 300 branch events -> flush_count holds 8'hFF.
REQ-023 reset=1 in cycle after ex_brTaken (state FLUSH) -> next cycle state RUN, counters 0, all control outputs 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls ID on load-use and flag hazards, and flushes IF/ID and ID/EX
// for two cycles after a taken branch. Also counts stall cycles and flush events, saturating.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_RnAddr,
  input  logic [4:0]  id_RmAddr,
  input  logic        id_usesRn,
  input  logic        id_usesRm,
  input  logic        id_isCondBr,
  input  logic [4:0]  ex_RdAddr,
  input  logic        ex_read_enable,
  input  logic        ex_RegWrite,
  input  logic        ex_flagEn,
  input  logic        ex_brTaken,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_count,
  output logic [7:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

  state_t      state_reg;
  logic [15:0] stall_count_reg;
  logic [7:0]  flush_count_reg;
  logic        load_use;
  logic        flag_haz;
  logic        stall;
  logic        flush;

  // XZR (register 31) never carries a real result, so it never creates a dependency.
  assign load_use = ex_read_enable & ex_RegWrite & (ex_RdAddr != 5'd31) &
                    ((id_usesRn & (id_RnAddr == ex_RdAddr)) |
                     (id_usesRm & (id_RmAddr == ex_RdAddr)));
  assign flag_haz = ex_flagEn & id_isCondBr;

  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          flush = ex_brTaken;
          stall = ~ex_brTaken & (load_use | flag_haz);
        end
        FLUSH: flush = 1'b1;
        default: begin
          stall = 1'b0;
          flush = 1'b0;
        end
      endcase
    end
  end

  assign pc_hold     = stall;
  assign ifid_hold   = stall;
  assign ifid_flush  = flush;
  assign idex_bubble = stall | flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      stall_count_reg <= 16'd0;
      flush_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (ex_brTaken) begin
            state_reg <= FLUSH;
            if (flush_count_reg != 8'hFF)
              flush_count_reg <= flush_count_reg + 8'd1;
          end else if (load_use | flag_haz) begin
            if (stall_count_reg != 16'hFFFF)
              stall_count_reg <= stall_count_reg + 16'd1;
          end
        end
        // Second flush cycle: the branch in EX is already a bubble, so nothing is re-evaluated.
        FLUSH:   state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign ctrl_state  = state_reg;
  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard detection, branch flush, priority, reset and
// counter saturation, with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_RnAddr, id_RmAddr, ex_RdAddr;
  logic        id_usesRn, id_usesRm, id_isCondBr;
  logic        ex_read_enable, ex_RegWrite, ex_flagEn, ex_brTaken;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;
  logic [7:0]  flush_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_RnAddr(id_RnAddr), .id_RmAddr(id_RmAddr),
    .id_usesRn(id_usesRn), .id_usesRm(id_usesRm), .id_isCondBr(id_isCondBr),
    .ex_RdAddr(ex_RdAddr), .ex_read_enable(ex_read_enable), .ex_RegWrite(ex_RegWrite),
    .ex_flagEn(ex_flagEn), .ex_brTaken(ex_brTaken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ctrl_state(ctrl_state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {pc_hold, ifid_hold, ifid_flush, idex_bubble}.
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_hold, ifid_hold, ifid_flush, idex_bubble}, {28'd0, exp});
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] st, input logic [15:0] sc,
                          input logic [7:0] fc);
    chk({tag, "_state"}, {30'd0, ctrl_state}, {30'd0, st});
    chk({tag, "_stall"}, {16'd0, stall_count}, {16'd0, sc});
    chk({tag, "_flush"}, {24'd0, flush_count}, {24'd0, fc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_RnAddr = 5'd0; id_RmAddr = 5'd0; id_usesRn = 1'b0; id_usesRm = 1'b0;
    id_isCondBr = 1'b0; ex_RdAddr = 5'd0; ex_read_enable = 1'b0; ex_RegWrite = 1'b0;
    ex_flagEn = 1'b0; ex_brTaken = 1'b0;
  endtask

  task automatic load_use_x3();
    ex_RdAddr = 5'd3; ex_read_enable = 1'b1; ex_RegWrite = 1'b1;
    id_RnAddr = 5'd3; id_usesRn = 1'b1;
  endtask

  initial begin
    // Reset with a hazard and a taken branch on the inputs: controls must stay 0.
    reset = 1'b1;
    idle();
    load_use_x3();
    ex_brTaken = 1'b1;
    #1;
    chk_ctrl("reset_ctrl", 4'b0000);
    step();
    step();
    chk_regs("reset", 2'd0, 16'd0, 8'd0);
    chk_ctrl("reset_ctrl_hold", 4'b0000);

    reset = 1'b0;
    idle();
    #1;
    chk_ctrl("idle_ctrl", 4'b0000);

    // Load-use on Rn: one bubble, then hazard clears once EX holds the bubble.
    load_use_x3();
    #1;
    chk_ctrl("lu_rn_ctrl", 4'b1101);
    step();
    chk_regs("lu_rn", 2'd0, 16'd1, 8'd0);
    ex_read_enable = 1'b0;
    #1;
    chk_ctrl("lu_clear_ctrl", 4'b0000);
    step();
    chk_regs("lu_clear", 2'd0, 16'd1, 8'd0);

    // Load-use on Rm.
    idle();
    ex_RdAddr = 5'd5; ex_read_enable = 1'b1; ex_RegWrite = 1'b1;
    id_RmAddr = 5'd5; id_usesRm = 1'b1; id_RnAddr = 5'd5;
    #1;
    chk_ctrl("lu_rm_ctrl", 4'b1101);
    step();
    chk_regs("lu_rm", 2'd0, 16'd2, 8'd0);

    // Rm matches but instruction does not read it.
    id_usesRm = 1'b0;
    #1;
    chk_ctrl("lu_rm_unused_ctrl", 4'b0000);

    // XZR destination never hazards.
    idle();
    ex_RdAddr = 5'd31; ex_read_enable = 1'b1; ex_RegWrite = 1'b1;
    id_RnAddr = 5'd31; id_RmAddr = 5'd31; id_usesRn = 1'b1; id_usesRm = 1'b1;
    #1;
    chk_ctrl("xzr_ctrl", 4'b0000);
    step();
    chk_regs("xzr", 2'd0, 16'd2, 8'd0);

    // Load without RegWrite is no hazard.
    idle();
    load_use_x3();
    ex_RegWrite = 1'b0;
    #1;
    chk_ctrl("no_regwrite_ctrl", 4'b0000);

    // Flag hazard with and without B.cond in ID.
    idle();
    ex_flagEn = 1'b1; id_isCondBr = 1'b1;
    #1;
    chk_ctrl("flag_ctrl", 4'b1101);
    step();
    chk_regs("flag", 2'd0, 16'd3, 8'd0);
    id_isCondBr = 1'b0;
    #1;
    chk_ctrl("flag_nobr_ctrl", 4'b0000);
    step();
    chk_regs("flag_nobr", 2'd0, 16'd3, 8'd0);

    // Taken branch overrides a concurrent load-use; FLUSH ignores both branch and hazard.
    idle();
    load_use_x3();
    ex_brTaken = 1'b1;
    #1;
    chk_ctrl("br_lu_ctrl", 4'b0011);
    step();
    chk_regs("br_lu", 2'd1, 16'd3, 8'd1);
    chk_ctrl("flush2_ctrl", 4'b0011);
    step();
    chk_regs("flush2", 2'd0, 16'd3, 8'd1);

    // Reset while in FLUSH.
    idle();
    ex_brTaken = 1'b1;
    #1;
    step();
    chk_regs("pre_rst_flush", 2'd1, 16'd3, 8'd2);
    reset = 1'b1;
    #1;
    chk_ctrl("rst_in_flush_ctrl", 4'b0000);
    step();
    reset = 1'b0;
    idle();
    #1;
    chk_regs("rst_in_flush", 2'd0, 16'd0, 8'd0);
    chk_ctrl("rst_in_flush_after_ctrl", 4'b0000);

    // Stall counter saturation: 65540 consecutive hazard cycles.
    load_use_x3();
    for (int i = 0; i < 65534; i++) step();
    chk_regs("stall_fffe", 2'd0, 16'hFFFE, 8'd0);
    step();
    chk_regs("stall_ffff", 2'd0, 16'hFFFF, 8'd0);
    for (int i = 0; i < 5; i++) step();
    chk_regs("stall_sat", 2'd0, 16'hFFFF, 8'd0);
    chk_ctrl("stall_sat_ctrl", 4'b1101);

    // Flush counter saturation: branch held high gives one event per two cycles.
    idle();
    ex_brTaken = 1'b1;
    for (int i = 0; i < 510; i++) step();
    chk_regs("flush_fe_run", 2'd0, 16'hFFFF, 8'hFF);
    for (int i = 0; i < 90; i++) step();
    chk_regs("flush_sat", 2'd0, 16'hFFFF, 8'hFF);
    chk_ctrl("flush_sat_ctrl", 4'b0011);

    idle();
    #1;
    chk_ctrl("final_idle_ctrl", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
